// File: rtl/uf_pkg.sv
// Shared opcode and FSM state encodings for the union-find label resolver.
package uf_pkg;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_UNION   = 2'b01;
    localparam logic [1:0] OP_FIND    = 2'b10;
    localparam logic [1:0] OP_RESOLVE = 2'b11;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_CLEAR      = 4'd1;
    localparam logic [3:0] S_FIND_RD    = 4'd2;
    localparam logic [3:0] S_FIND_CHK   = 4'd3;
    localparam logic [3:0] S_FIND_CMP   = 4'd4;
    localparam logic [3:0] S_UNION_A    = 4'd5;
    localparam logic [3:0] S_UNION_B    = 4'd6;
    localparam logic [3:0] S_UNION_LINK = 4'd7;
    localparam logic [3:0] S_RES_RD     = 4'd8;
    localparam logic [3:0] S_RES_FIN    = 4'd9;
    localparam logic [3:0] S_RES_OUT    = 4'd10;
    localparam logic [3:0] S_RSP        = 4'd11;

endpackage

// File: rtl/uf_spram.sv
// Single-port RAM with one-cycle registered read; contents are never reset.
module uf_spram #(
    parameter int DEPTH = 256,
    parameter int DW    = 8,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [IW-1:0] idx;
    logic          in_range;

    assign idx      = addr[IW-1:0];
    assign in_range = 32'(addr) < DEPTH;

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/union_find_resolve.sv
// Union-find over N labels with path-halving FIND, min-root UNION and a
// streaming RESOLVE pass that assigns compact final IDs to every label.
//
// state        | meaning
// IDLE         | waiting for a request
// CLEAR        | writing parent[i]=i, one entry per cycle
// FIND_RD      | read parent[x]
// FIND_CHK     | x is root, or read grandparent
// FIND_CMP     | halve path: parent[x]=grandparent, continue from it
// UNION_A      | root of req_a captured, start walk of req_b
// UNION_B      | compare both roots
// UNION_LINK   | parent[max root]=min root
// RES_RD       | read parent[i]
// RES_FIN      | assign new id or fetch final[parent[i]]
// RES_OUT      | present (i, final[i]) on the stream
// RSP          | one-cycle response pulse
module union_find_resolve
    import uf_pkg::*;
#(
    parameter int N   = 256,
    parameter int AW  = 8,
    parameter int IDW = AW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_start,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_op,
    input  logic [AW-1:0]  req_a,
    input  logic [AW-1:0]  req_b,
    output logic           rsp_valid,
    output logic [AW-1:0]  rsp_root,
    output logic           rsp_same,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [AW-1:0]  out_label,
    output logic [IDW-1:0] out_id,
    output logic [IDW:0]   num_ids,
    output logic           busy,
    output logic           err
);
    localparam logic [AW:0]   LIMIT = (AW+1)'(N);
    localparam logic [AW-1:0] LAST  = AW'(N-1);

    logic [3:0]     state;
    logic [1:0]     op_q;
    logic [AW-1:0]  idx, x_q, b_q, p_q, ra, root_q;
    logic           phase, fin_phase;
    logic [IDW:0]   next_id;

    logic           par_we, fin_we;
    logic [AW-1:0]  par_addr, par_wdata, par_rdata, fin_addr;
    logic [IDW-1:0] fin_wdata, fin_rdata;
    logic [AW-1:0]  link_lo, link_hi;
    logic [3:0]     walk_next;
    logic           bad;

    assign req_ready = (state == S_IDLE) && !frame_start;
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RSP);
    assign out_valid = (state == S_RES_OUT);
    assign out_label = idx;

    assign link_lo = (ra < root_q) ? ra : root_q;
    assign link_hi = (ra < root_q) ? root_q : ra;

    assign walk_next = (op_q == OP_FIND) ? S_RSP : (phase ? S_UNION_B : S_UNION_A);

    assign bad = (req_op == OP_NOP)
              || (((req_op == OP_FIND) || (req_op == OP_UNION)) && ({1'b0, req_a} >= LIMIT))
              || ((req_op == OP_UNION) && ({1'b0, req_b} >= LIMIT));

    always_comb begin
        par_we    = 1'b0;
        par_addr  = x_q;
        par_wdata = par_rdata;
        fin_we    = 1'b0;
        fin_addr  = idx;
        fin_wdata = fin_rdata;
        case (state)
            S_CLEAR: begin
                par_we    = 1'b1;
                par_addr  = idx;
                par_wdata = idx;
            end
            S_FIND_CHK: par_addr = par_rdata;
            S_FIND_CMP: par_we = 1'b1;
            S_UNION_LINK: begin
                par_we    = 1'b1;
                par_addr  = link_hi;
                par_wdata = link_lo;
            end
            S_RES_RD: par_addr = idx;
            S_RES_FIN: begin
                if (fin_phase) begin
                    fin_we = 1'b1;
                end else if (par_rdata == idx) begin
                    fin_we    = 1'b1;
                    fin_wdata = next_id[IDW-1:0];
                end else begin
                    fin_addr = par_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= OP_NOP;
            idx       <= '0;
            x_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            ra        <= '0;
            root_q    <= '0;
            phase     <= 1'b0;
            fin_phase <= 1'b0;
            next_id   <= '0;
            rsp_root  <= '0;
            rsp_same  <= 1'b0;
            out_id    <= '0;
            num_ids   <= '0;
            err       <= 1'b0;
        end else if (frame_start) begin
            state <= S_CLEAR;
            idx   <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    op_q     <= req_op;
                    x_q      <= req_a;
                    b_q      <= req_b;
                    phase    <= 1'b0;
                    rsp_same <= 1'b0;
                    if (bad) begin
                        err      <= 1'b1;
                        rsp_root <= '0;
                        state    <= S_RSP;
                    end else if (req_op == OP_RESOLVE) begin
                        idx       <= '0;
                        next_id   <= '0;
                        fin_phase <= 1'b0;
                        state     <= S_RES_RD;
                    end else begin
                        state <= S_FIND_RD;
                    end
                end
                S_CLEAR: begin
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= S_IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_FIND_RD: state <= S_FIND_CHK;
                S_FIND_CHK: begin
                    if (par_rdata == x_q) begin
                        root_q   <= x_q;
                        rsp_root <= x_q;
                        state    <= walk_next;
                    end else begin
                        p_q   <= par_rdata;
                        state <= S_FIND_CMP;
                    end
                end
                // grandparent equal to parent means the parent is the root
                S_FIND_CMP: begin
                    if (par_rdata == p_q) begin
                        root_q   <= p_q;
                        rsp_root <= p_q;
                        state    <= walk_next;
                    end else begin
                        x_q   <= par_rdata;
                        state <= S_FIND_RD;
                    end
                end
                S_UNION_A: begin
                    ra    <= root_q;
                    x_q   <= b_q;
                    phase <= 1'b1;
                    state <= S_FIND_RD;
                end
                S_UNION_B: begin
                    rsp_root <= link_lo;
                    if (ra == root_q) begin
                        rsp_same <= 1'b1;
                        state    <= S_RSP;
                    end else begin
                        state <= S_UNION_LINK;
                    end
                end
                S_UNION_LINK: state <= S_RSP;
                S_RES_RD: state <= S_RES_FIN;
                S_RES_FIN: begin
                    if (fin_phase) begin
                        out_id    <= fin_rdata;
                        fin_phase <= 1'b0;
                        state     <= S_RES_OUT;
                    end else if (par_rdata == idx) begin
                        out_id  <= next_id[IDW-1:0];
                        next_id <= next_id + 1'b1;
                        state   <= S_RES_OUT;
                    end else begin
                        fin_phase <= 1'b1;
                    end
                end
                S_RES_OUT: if (out_ready) begin
                    if (idx == LAST) begin
                        num_ids  <= next_id;
                        rsp_root <= '0;
                        rsp_same <= 1'b0;
                        idx      <= '0;
                        state    <= S_RSP;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_RES_RD;
                    end
                end
                S_RSP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    uf_spram #(.DEPTH(N), .DW(AW), .AW(AW)) u_parent (
        .clk   (clk),
        .we    (par_we),
        .addr  (par_addr),
        .wdata (par_wdata),
        .rdata (par_rdata)
    );

    uf_spram #(.DEPTH(N), .DW(IDW), .AW(AW)) u_final (
        .clk   (clk),
        .we    (fin_we),
        .addr  (fin_addr),
        .wdata (fin_wdata),
        .rdata (fin_rdata)
    );

endmodule

// File: tb/tb_union_find_resolve.sv
// Bench for union_find_resolve: N=256 labels on 9-bit labels so out-of-range
// requests can be expressed; checked against a set-partition model.
module tb_union_find_resolve;
    localparam int N   = 256;
    localparam int AW  = 9;
    localparam int IDW = 9;

    logic           clk, reset, frame_start, req_valid, req_ready;
    logic [1:0]     req_op;
    logic [AW-1:0]  req_a, req_b, rsp_root, out_label;
    logic           rsp_valid, rsp_same, out_valid, out_ready, busy, err;
    logic [IDW-1:0] out_id;
    logic [IDW:0]   num_ids;

    int compared = 0;
    int mismatched = 0;

    int comp [N];
    int exp_id [N];
    int exp_num;
    int got_label [$];
    int got_id [$];

    union_find_resolve #(.N(N), .AW(AW), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_root(rsp_root), .rsp_same(rsp_same), .out_valid(out_valid),
        .out_ready(out_ready), .out_label(out_label), .out_id(out_id),
        .num_ids(num_ids), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // comp[i] is the smallest label of i's set, which is what the root must be
    task automatic model_clear();
        for (int i = 0; i < N; i++) comp[i] = i;
    endtask

    task automatic model_union(input int a, input int b);
        int ma, mb, lo;
        ma = comp[a];
        mb = comp[b];
        lo = (ma < mb) ? ma : mb;
        for (int i = 0; i < N; i++)
            if (comp[i] == ma || comp[i] == mb) comp[i] = lo;
    endtask

    task automatic model_resolve();
        exp_num = 0;
        for (int i = 0; i < N; i++) begin
            if (comp[i] == i) begin
                exp_id[i] = exp_num;
                exp_num++;
            end else begin
                exp_id[i] = exp_id[comp[i]];
            end
        end
    endtask

    task automatic issue_req(input logic [1:0] op, input int a, input int b, output bit acc);
        int n;
        n = 0;
        @(negedge clk);
        req_op = op;
        req_a = AW'(a);
        req_b = AW'(b);
        req_valid = 1'b1;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        acc = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input int a, input int b,
                         output bit got, output int root, output bit same);
        bit acc;
        int n;
        issue_req(op, a, b, acc);
        n = 0;
        while (!rsp_valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        got = acc && rsp_valid;
        root = int'(rsp_root);
        same = rsp_same;
    endtask

    task automatic do_clear(output int cycles);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        cycles = 0;
        while (busy && cycles < 1000) begin
            cycles++;
            @(negedge clk);
        end
        model_clear();
    endtask

    task automatic collect_resolve(input int pct, output bit done, output int unstable,
                                   output int nids);
        logic pv, pr;
        logic [AW-1:0] pl;
        logic [IDW-1:0] pid;
        pv = 1'b0;
        pr = 1'b0;
        pl = '0;
        pid = '0;
        done = 1'b0;
        unstable = 0;
        nids = -1;
        got_label.delete();
        got_id.delete();
        for (int c = 0; c < 20000; c++) begin
            if (rsp_valid) begin
                done = 1'b1;
                nids = int'(num_ids);
                break;
            end
            out_ready = ($urandom_range(99) < pct);
            if (out_valid && pv && !pr && (out_label !== pl || out_id !== pid)) unstable++;
            if (out_valid && out_ready) begin
                got_label.push_back(int'(out_label));
                got_id.push_back(int'(out_id));
            end
            pv = out_valid;
            pr = out_ready;
            pl = out_label;
            pid = out_id;
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        frame_start = 1'b1;
        req_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_over_frame_start: busy=%0b required 0", busy);
        end
        frame_start = 1'b0;
        @(negedge clk);
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_req_ready: got %0b required 1", req_ready);
        end
        compared++;
        if ({rsp_valid, rsp_root, rsp_same, out_valid, out_label, out_id, num_ids, busy, err} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: rsp_valid=%0b rsp_root=%0d rsp_same=%0b out_valid=%0b out_label=%0d out_id=%0d num_ids=%0d busy=%0b err=%0b required all 0",
                     rsp_valid, rsp_root, rsp_same, out_valid, out_label, out_id, num_ids, busy, err);
        end
        reset = 1'b0;
    endtask

    task automatic test_clear();
        int cyc, root;
        bit got, same;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        compared++;
        if (req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL clear_req_ready: got %0b required 0", req_ready);
        end
        cyc = 0;
        while (busy && cyc < 1000) begin
            cyc++;
            @(negedge clk);
        end
        model_clear();
        compared++;
        if (cyc != N) begin
            mismatched++;
            $display("FAIL clear_busy_cycles: got %0d required %0d", cyc, N);
        end
        do_op(2'b10, 5, 0, got, root, same);
        compared++;
        if (!got || root != 5 || same !== 1'b0 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL clear_find5: got rsp=%0b root=%0d same=%0b err=%0b required 1/5/0/0", got, root, same, err);
        end
    endtask

    task automatic test_chain();
        int root;
        bit got, same;
        do_op(2'b01, 3, 7, got, root, same);
        model_union(3, 7);
        compared++;
        if (!got || root != 3 || same !== 1'b0) begin
            mismatched++;
            $display("FAIL chain_union_3_7: got rsp=%0b root=%0d same=%0b required 1/3/0", got, root, same);
        end
        do_op(2'b01, 7, 9, got, root, same);
        model_union(7, 9);
        compared++;
        if (!got || root != 3 || same !== 1'b0) begin
            mismatched++;
            $display("FAIL chain_union_7_9: got rsp=%0b root=%0d same=%0b required 1/3/0", got, root, same);
        end
        do_op(2'b10, 9, 0, got, root, same);
        compared++;
        if (!got || root != 3 || same !== 1'b0) begin
            mismatched++;
            $display("FAIL chain_find9: got rsp=%0b root=%0d same=%0b required 1/3/0", got, root, same);
        end
        do_op(2'b01, 9, 3, got, root, same);
        compared++;
        if (!got || root != 3 || same !== 1'b1) begin
            mismatched++;
            $display("FAIL chain_union_9_3_same: got rsp=%0b root=%0d same=%0b required 1/3/1", got, root, same);
        end
    endtask

    task automatic test_resolve_basic();
        int cyc, root, unstable, nids, bad;
        bit got, same, done, acc;
        int want [8] = '{0, 1, 1, 2, 1, 3, 1, 4};
        do_clear(cyc);
        do_op(2'b01, 1, 4, got, root, same);
        model_union(1, 4);
        do_op(2'b01, 2, 6, got, root, same);
        model_union(2, 6);
        do_op(2'b01, 4, 6, got, root, same);
        model_union(4, 6);
        compared++;
        if (!got || root != 1) begin
            mismatched++;
            $display("FAIL resolve_union_4_6: got rsp=%0b root=%0d required 1/1", got, root);
        end
        model_resolve();
        issue_req(2'b11, 0, 0, acc);
        collect_resolve(100, done, unstable, nids);
        compared++;
        if (!done || got_label.size() != N) begin
            mismatched++;
            $display("FAIL resolve_basic_stream: done=%0b count=%0d required 1/%0d", done, got_label.size(), N);
        end
        for (int i = 0; i < 8 && i < got_id.size(); i++) begin
            compared++;
            if (got_label[i] != i || got_id[i] != want[i]) begin
                mismatched++;
                $display("FAIL resolve_basic_id: entry %0d got label %0d id %0d required label %0d id %0d",
                         i, got_label[i], got_id[i], i, want[i]);
            end
        end
        bad = 0;
        for (int i = 8; i < got_id.size(); i++)
            if (got_label[i] != i || got_id[i] != exp_id[i]) bad++;
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL resolve_basic_tail: %0d entries wrong, required 0", bad);
        end
        compared++;
        if (nids != N - 3 || nids != exp_num) begin
            mismatched++;
            $display("FAIL resolve_basic_num_ids: got %0d required %0d", nids, N - 3);
        end
    endtask

    task automatic test_random_backpressure();
        int cyc, root, a, b, er, unstable, nids, bad_lbl, bad_id;
        bit got, same, es, done, acc;
        do_clear(cyc);
        for (int k = 0; k < 60; k++) begin
            a = $urandom_range(47);
            b = $urandom_range(47);
            if ($urandom_range(3) != 0) begin
                er = (comp[a] < comp[b]) ? comp[a] : comp[b];
                es = (comp[a] == comp[b]);
                do_op(2'b01, a, b, got, root, same);
                model_union(a, b);
            end else begin
                er = comp[a];
                es = 1'b0;
                do_op(2'b10, a, 0, got, root, same);
            end
            compared++;
            if (!got || root != er || same !== es) begin
                mismatched++;
                $display("FAIL random_op_%0d: a=%0d b=%0d got rsp=%0b root=%0d same=%0b required root=%0d same=%0b",
                         k, a, b, got, root, same, er, es);
            end
        end
        model_resolve();
        issue_req(2'b11, 0, 0, acc);
        collect_resolve(40, done, unstable, nids);
        bad_lbl = 0;
        bad_id = 0;
        for (int i = 0; i < got_label.size(); i++) begin
            if (got_label[i] != i) bad_lbl++;
            else if (got_id[i] != exp_id[i]) bad_id++;
        end
        compared++;
        if (!done || got_label.size() != N || bad_lbl != 0) begin
            mismatched++;
            $display("FAIL bp_order: done=%0b count=%0d out_of_order=%0d required 1/%0d/0", done, got_label.size(), bad_lbl, N);
        end
        compared++;
        if (bad_id != 0) begin
            mismatched++;
            $display("FAIL bp_ids: %0d wrong ids, required 0", bad_id);
        end
        compared++;
        if (unstable != 0) begin
            mismatched++;
            $display("FAIL bp_stall_hold: %0d changes while stalled, required 0", unstable);
        end
        compared++;
        if (nids != exp_num) begin
            mismatched++;
            $display("FAIL bp_num_ids: got %0d required %0d", nids, exp_num);
        end
    endtask

    task automatic test_error();
        int root;
        bit got, same;
        do_op(2'b10, 300, 0, got, root, same);
        compared++;
        if (!got || root != 0 || err !== 1'b1) begin
            mismatched++;
            $display("FAIL err_find300: got rsp=%0b root=%0d err=%0b required 1/0/1", got, root, err);
        end
        do_op(2'b00, 1, 2, got, root, same);
        compared++;
        if (!got || root != 0 || err !== 1'b1) begin
            mismatched++;
            $display("FAIL err_reserved_op: got rsp=%0b root=%0d err=%0b required 1/0/1", got, root, err);
        end
        do_op(2'b01, 40, 300, got, root, same);
        compared++;
        if (!got || root != 0) begin
            mismatched++;
            $display("FAIL err_union_range: got rsp=%0b root=%0d required 1/0", got, root);
        end
        do_op(2'b10, 40, 0, got, root, same);
        compared++;
        if (!got || root != comp[40] || err !== 1'b1) begin
            mismatched++;
            $display("FAIL err_table_intact: got rsp=%0b root=%0d err=%0b required 1/%0d/1", got, root, err, comp[40]);
        end
    endtask

    task automatic test_abort();
        int cyc, hs, pulses, root;
        bit got, same, acc;
        do_clear(cyc);
        do_op(2'b01, 2, 6, got, root, same);
        issue_req(2'b11, 0, 0, acc);
        out_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 2000 && hs < 20; c++) begin
            if (out_valid && out_ready) hs++;
            if (hs < 20) @(negedge clk);
        end
        compared++;
        if (hs < 20) begin
            mismatched++;
            $display("FAIL abort_stream_start: got %0d handshakes required 20", hs);
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        out_ready = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_out_valid: got out_valid=%0b busy=%0b required 0/1", out_valid, busy);
        end
        pulses = 0;
        cyc = 0;
        while (busy && cyc < 1000) begin
            if (rsp_valid) pulses++;
            cyc++;
            @(negedge clk);
        end
        model_clear();
        compared++;
        if (pulses != 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_no_rsp: got %0d pulses busy=%0b required 0/0", pulses, busy);
        end
        do_op(2'b10, 6, 0, got, root, same);
        compared++;
        if (!got || root != 6) begin
            mismatched++;
            $display("FAIL abort_find6: got rsp=%0b root=%0d required 1/6", got, root);
        end
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        req_valid = 1'b0;
        req_op = 2'b00;
        req_a = '0;
        req_b = '0;
        out_ready = 1'b0;
        test_reset();
        test_clear();
        test_chain();
        test_resolve_basic();
        test_random_backpressure();
        test_error();
        test_abort();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
